led_share_arbiter: RTL and testbench

LED_SHARE_ARBITER -- requirements
Module: led_share_arbiter

---
 rtl/led_share_if.sv | 11 +
 rtl/led_share_arbiter.sv | 121 ++++++++++++
 tb/tb_led_share_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/led_share_if.sv
// Requester-side bundle for the shared LED bank: requests and patterns in,
// grant and busy back out.
interface led_share_if;
    logic [2:0]  req;
    logic [14:0] pat;
    logic [2:0]  gnt;
    logic        busy;

    modport master (output req, pat, input gnt, busy);
    modport slave  (input req, pat, output gnt, busy);
endinterface

// File: rtl/led_share_arbiter.sv
// Round-robin arbiter sharing one 5-LED bank among three requesters, with a
// tenure limit and a gray-code idle animation when nobody owns the bank.
module led_share_arbiter #(
    parameter int LOG2DELAY  = 22,
    parameter int MAX_TENURE = 4096
) (
    input  logic        clk,
    input  logic        rst,
    led_share_if.slave  bus,
    output logic        LED1,
    output logic        LED2,
    output logic        LED3,
    output logic        LED4,
    output logic        LED5
);
    localparam int CW = 5 + LOG2DELAY;
    localparam int TW = $clog2(MAX_TENURE);
    localparam logic [TW-1:0] TEN_MAX = TW'(MAX_TENURE - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic [1:0]    last_q, last_d;
    logic [TW-1:0] ten_q, ten_d;
    logic [CW-1:0] anim_q, anim_d;
    logic [4:0]    led_q, led_d;
    logic [2:0]    gnt_q, gnt_d;
    logic [1:0]    win;
    logic          win_vld;
    logic [4:0]    anim_bin;

    function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, k};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    function automatic logic [4:0] pat_of(input logic [14:0] p, input logic [1:0] i);
        case (i)
            2'd0:    return p[4:0];
            2'd1:    return p[9:5];
            default: return p[14:10];
        endcase
    endfunction

    // Walk from farthest to nearest so the requester right after last_owner wins.
    always_comb begin
        win     = 2'd0;
        win_vld = 1'b0;
        for (int k = 3; k >= 1; k--) begin
            if (bus.req[rr_idx(last_q, 2'(k))]) begin
                win     = rr_idx(last_q, 2'(k));
                win_vld = 1'b1;
            end
        end
    end

    assign anim_bin = anim_d[CW-1 -: 5];

    always_comb begin
        anim_d  = anim_q + 1'b1;
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        ten_d   = ten_q;
        led_d   = led_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: begin
                gnt_d = 3'b000;
                led_d = anim_bin ^ (anim_bin >> 1);
                if (win_vld) begin
                    state_d = GRANT;
                    owner_d = win;
                    ten_d   = '0;
                    gnt_d   = 3'b001 << win;
                    led_d   = pat_of(bus.pat, win);
                end
            end
            GRANT: begin
                led_d = pat_of(bus.pat, owner_q);
                if (ten_q != TEN_MAX) ten_d = ten_q + 1'b1;
                // gnt_q is the owner's one-hot, so it doubles as the owner mask.
                if (!(|(bus.req & gnt_q)) ||
                    ((ten_q == TEN_MAX) && (|(bus.req & ~gnt_q)))) begin
                    state_d = IDLE;
                    gnt_d   = 3'b000;
                    last_d  = owner_q;
                    led_d   = led_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            last_q  <= 2'd2;
            ten_q   <= '0;
            anim_q  <= '0;
            led_q   <= 5'b0;
            gnt_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            ten_q   <= ten_d;
            anim_q  <= anim_d;
            led_q   <= led_d;
            gnt_q   <= gnt_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.busy = (state_q == GRANT);
    assign {LED1, LED2, LED3, LED4, LED5} = led_q;
endmodule

// File: tb/tb_led_share_arbiter.sv
// Directed bench for led_share_arbiter at LOG2DELAY=2, MAX_TENURE=8.
module tb_led_share_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic LED1, LED2, LED3, LED4, LED5;
    logic [4:0] leds;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [2:0] order [4];

    led_share_if bus();

    led_share_arbiter #(.LOG2DELAY(2), .MAX_TENURE(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .LED1(LED1),
        .LED2(LED2),
        .LED3(LED3),
        .LED4(LED4),
        .LED5(LED5)
    );

    always #5 clk = ~clk;
    assign leds = {LED1, LED2, LED3, LED4, LED5};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected animation frame for a given counter value (7-bit counter).
    function automatic logic [4:0] gray5(input int c);
        logic [4:0] b;
        b = 5'((c % 128) >> 2);
        return b ^ (b >> 1);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_led", 32'(leds), 32'd0);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        rst     = 1'b1;
        bus.req = 3'b000;
        bus.pat = 15'd0;
        order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;

        // Idle animation over one full wrap
        do_reset();
        check("first_led", 32'(leds), 32'd0);
        for (int k = 1; k <= 128; k++) begin
            step();
            check("anim", 32'(leds), 32'(gray5(k)));
            if (k == 4)   check("anim_4",   32'(leds), 32'b00001);
            if (k == 8)   check("anim_8",   32'(leds), 32'b00011);
            if (k == 12)  check("anim_12",  32'(leds), 32'b00010);
            if (k == 16)  check("anim_16",  32'(leds), 32'b00110);
            if (k == 128) check("anim_wrap", 32'(leds), 32'b00000);
        end

        // Single owner, release by drop, one-cycle LED hold
        bus.req = 3'b001;
        bus.pat = {5'b00000, 5'b00000, 5'b10101};
        step();
        check("own_gnt", 32'(bus.gnt), 32'b001);
        check("own_busy", 32'(bus.busy), 32'd1);
        check("own_led", 32'(leds), 32'b10101);
        for (int k = 0; k < 19; k++) begin
            step();
            check("own_hold", 32'(bus.gnt), 32'b001);
        end
        bus.req = 3'b000;
        step();
        check("drop_gnt", 32'(bus.gnt), 32'd0);
        check("drop_busy", 32'(bus.busy), 32'd0);
        check("drop_led_hold", 32'(leds), 32'b10101);
        step();
        check("anim_resume", 32'(leds), 32'(gray5(cyc)));
        step();
        check("anim_resume2", 32'(leds), 32'(gray5(cyc)));

        // All three request: 0,1,2,0 with one empty cycle between grants
        do_reset();
        bus.req = 3'b111;
        bus.pat = {5'b00100, 5'b00010, 5'b00001};
        for (int i = 0; i < 4; i++) begin
            for (int t = 0; t < 8; t++) begin
                step();
                check("rr_gnt", 32'(bus.gnt), 32'(order[i]));
                check("rr_led", 32'(leds), 32'({2'b00, order[i]}));
            end
            if (i < 3) begin
                step();
                check("rr_gap", 32'(bus.gnt), 32'd0);
                check("rr_gap_led", 32'(leds), 32'({2'b00, order[i]}));
            end
        end

        // Saturated tenure with no competitor, then preemption
        do_reset();
        bus.req = 3'b010;
        step();
        check("sat_first", 32'(bus.gnt), 32'b010);
        for (int k = 0; k < 50; k++) begin
            step();
            check("sat_hold", 32'(bus.gnt), 32'b010);
        end
        bus.req = 3'b011;
        step();
        check("sat_preempt", 32'(bus.gnt), 32'd0);
        step();
        check("sat_next", 32'(bus.gnt), 32'b001);

        // Reset mid-grant, then re-grant, latency, non-owner noise
        do_reset();
        bus.req = 3'b100;
        bus.pat = {5'b01010, 5'b00000, 5'b00000};
        step();
        check("g2_gnt", 32'(bus.gnt), 32'b100);
        step();
        rst = 1'b1;
        step();
        check("midrst_gnt", 32'(bus.gnt), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_led", 32'(leds), 32'd0);
        rst = 1'b0;
        cyc = 0;
        step();
        check("regrant", 32'(bus.gnt), 32'b100);
        check("regrant_busy", 32'(bus.busy), 32'd1);
        bus.pat = {5'b00000, 5'b00000, 5'b00000};
        step();
        check("lat_zero", 32'(leds), 32'b00000);
        bus.pat = {5'b11111, 5'b00000, 5'b00000};
        step();
        check("lat_ones", 32'(leds), 32'b11111);
        bus.req = 3'b101;
        step();
        check("noise1", 32'(bus.gnt), 32'b100);
        step();
        check("noise2", 32'(bus.gnt), 32'b100);
        bus.req = 3'b000;
        step();
        check("g2_drop", 32'(bus.gnt), 32'd0);
        check("g2_drop_led", 32'(leds), 32'b11111);
        step();
        check("g2_anim", 32'(leds), 32'(gray5(cyc)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
